// File: rtl/tcdm_bank_arbiter_ctrl.sv
// Round-robin arbiter sharing one 1-cycle-latency TCDM bank among NbReq requesters, with zero-fill sequencing.
// Optional per-requester stall counters are enabled with `define TCDM_ARB_PERF_EN.
module tcdm_bank_arbiter_ctrl #(
  parameter int unsigned NbReq     = 4,
  parameter int unsigned BankSize  = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           init_i,
  output logic                           init_done_o,
  input  logic [NbReq-1:0]               req_i,
  output logic [NbReq-1:0]               gnt_o,
  input  logic [NbReq-1:0]               wen_i,
  input  logic [NbReq*AddrWidth-1:0]     add_i,
  input  logic [NbReq*DataWidth-1:0]     data_i,
  input  logic [NbReq*DataWidth/8-1:0]   be_i,
  output logic [NbReq-1:0]               r_valid_o,
  output logic [DataWidth-1:0]           r_data_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [$clog2(BankSize)-1:0]    mem_addr_o,
  output logic [DataWidth-1:0]           mem_wdata_o,
  output logic [DataWidth/8-1:0]         mem_be_o,
  input  logic [DataWidth-1:0]           mem_rdata_i
`ifdef TCDM_ARB_PERF_EN
  ,
  output logic [NbReq*CntWidth-1:0]      stall_cnt_o,
  input  logic                           clr_cnt_i
`endif
);

  localparam int unsigned BankAw = $clog2(BankSize);
  localparam int unsigned IdxW   = $clog2(NbReq);
  localparam int unsigned BeW    = DataWidth / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [BankAw-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NbReq-1:0]     r_valid_q, r_valid_d;
  logic                 init_done_q, init_done_d;

  logic [BankAw-1:0]    word_addr [NbReq];
  logic [DataWidth-1:0] wdata_arr [NbReq];
  logic [BeW-1:0]       be_arr    [NbReq];
  logic [IdxW-1:0]      win;
  logic                 found;
  logic                 grant_en;
  logic                 unused_addr;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NbReq) s = s - NbReq;
    return IdxW'(s);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NbReq; i++) begin
      word_addr[i] = add_i[i*AddrWidth+2 +: BankAw];
      wdata_arr[i] = data_i[i*DataWidth +: DataWidth];
      be_arr[i]    = be_i[i*BeW +: BeW];
    end
  end

  // Address bits outside the word index are deliberately ignored.
  assign unused_addr = ^add_i;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NbReq; k++) begin
      if (!found && req_i[rr_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  assign grant_en = (state_q == ST_RUN) && found;
  assign gnt_o    = grant_en ? (NbReq'(1) << win) : '0;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = ~wen_i[win];
    mem_addr_o  = word_addr[win];
    mem_wdata_o = wdata_arr[win];
    mem_be_o    = be_arr[win];
    if (state_q == ST_INIT) begin
      // The reset state is already INIT, so the fill request is held off while rst_i is high.
      mem_req_o   = ~rst_i;
      mem_we_o    = 1'b1;
      mem_addr_o  = cnt_q;
      mem_wdata_o = '0;
      mem_be_o    = '1;
    end else begin
      mem_req_o   = grant_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    init_done_d = init_done_q;
    r_valid_d   = gnt_o;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BankAw'(BankSize - 1)) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (init_i) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (grant_en) rr_ptr_d = (win == IdxW'(NbReq - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      r_valid_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      r_valid_q   <= r_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign r_valid_o   = r_valid_q;
  assign r_data_o    = mem_rdata_i;
  assign init_done_o = init_done_q;

`ifdef TCDM_ARB_PERF_EN
  logic [CntWidth-1:0] stall_q [NbReq];
  logic [CntWidth-1:0] stall_d [NbReq];

  always_comb begin
    stall_cnt_o = '0;
    for (int unsigned i = 0; i < NbReq; i++) begin
      stall_d[i] = stall_q[i];
      if (clr_cnt_i) stall_d[i] = '0;
      else if (req_i[i] && !gnt_o[i] && (stall_q[i] != '1)) stall_d[i] = stall_q[i] + 1'b1;
      stall_cnt_o[i*CntWidth +: CntWidth] = stall_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NbReq; i++) stall_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NbReq; i++) stall_q[i] <= stall_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter_ctrl.sv
// Scoreboard bench for tcdm_bank_arbiter_ctrl: directed vectors, responses checked by a separate monitor.
module tb_tcdm_bank_arbiter_ctrl;
  localparam int NR = 4, BS = 256, DW = 32, AW = 32, CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic              init_done;
  logic [NR-1:0]     req, gnt, wen, r_valid;
  logic [NR*AW-1:0]  add;
  logic [NR*DW-1:0]  data;
  logic [NR*DW/8-1:0] be;
  logic [DW-1:0]     r_data;
  logic              mem_req, mem_we;
  logic [7:0]        mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [DW/8-1:0]   mem_be;
`ifdef TCDM_ARB_PERF_EN
  logic [NR*CW-1:0]  stall_cnt;
  logic              clr_cnt = 1'b0;
`endif

  always #5 clk = ~clk;

  tcdm_bank_arbiter_ctrl #(.NbReq(NR), .BankSize(BS), .DataWidth(DW), .AddrWidth(AW), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .init_i(init), .init_done_o(init_done),
    .req_i(req), .gnt_o(gnt), .wen_i(wen), .add_i(add), .data_i(data), .be_i(be),
    .r_valid_o(r_valid), .r_data_o(r_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
`ifdef TCDM_ARB_PERF_EN
    , .stall_cnt_o(stall_cnt), .clr_cnt_i(clr_cnt)
`endif
  );

  // Bank model: single port, one-cycle read latency, byte-enabled writes
  logic [DW-1:0] mem [BS];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < DW/8; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {int idx; bit rd; logic [31:0] data; int due;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] mon_oh;
  int total = 0, bad = 0, cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input int idx, input bit rd, input logic [31:0] d);
    exp_t e;
    e.idx = idx; e.rd = rd; e.data = d; e.due = cyc_n + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
      mon_e  = exp_q.pop_front();
      mon_oh = 4'b0001 << mon_e.idx;
      check("rvalid", 64'(r_valid), 64'(mon_oh));
      if (mon_e.rd) check("rdata", 64'(r_data), 64'(mon_e.data));
    end else if (r_valid !== '0) begin
      check("stray_rvalid", 64'(r_valid), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input bit rd, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wen[i] = rd;
    add[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
    be[i*4 +: 4] = b;
  endtask

  task automatic fill_check(input int unsigned n, input int unsigned inj);
    for (int unsigned k = 0; k < n; k++) begin
      init = (k == inj);
      @(negedge clk);
      check("fill", 64'({mem_req, mem_we, mem_addr, mem_be, gnt, init_done, mem_wdata}),
            64'({1'b1, 1'b1, 8'(k), 4'hF, 4'h0, 1'b0, 32'h0}));
      tick();
    end
    init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; init = 1'b0; req = '0; wen = '0; add = '0; data = '0; be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 64'({gnt, r_valid, init_done, mem_req}), 64'(0));
    tick();
    rst = 1'b0;

    // Zero-fill after reset, RUN on cycle 257
    fill_check(256, 999);
    @(negedge clk);
    check("init_done", 64'(init_done), 64'(1));
    check("idle", 64'({mem_req, gnt}), 64'(0));
    tick();

    // All four requesting: grants 0,1,2,3,0
    for (int i = 0; i < NR; i++) set_port(i, 1'b1, 32'(i * 4), 32'h0, 4'hF);
    req = 4'hF;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("rr_gnt", 64'(gnt), 64'(4'b0001 << (j % 4)));
      check("rr_addr", 64'({mem_addr, mem_we}), 64'({8'(j % 4), 1'b0}));
      push(j % 4, 1'b1, 32'h0);
      tick();
    end
    req = '0;

    // Write with partial byte enables, then read back
    set_port(2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011);
    req = 4'b0100;
    @(negedge clk);
    check("wr_gnt", 64'(gnt), 64'(4'b0100));
    check("wr_bank", 64'({mem_addr, mem_we, mem_be, mem_wdata}), 64'({8'h04, 1'b1, 4'h3, 32'hDEAD_BEEF}));
    push(2, 1'b0, 32'h0);
    tick();
    set_port(2, 1'b1, 32'h0000_0010, 32'h0, 4'hF);
    @(negedge clk);
    check("rd_bank", 64'({gnt, mem_addr, mem_we}), 64'({4'b0100, 8'h04, 1'b0}));
    push(2, 1'b1, 32'h0000_BEEF);
    tick();
    set_port(2, 1'b1, 32'hFFFF_F413, 32'h0, 4'hF);
    @(negedge clk);
    check("rd_hi_addr", 64'({gnt, mem_addr}), 64'({4'b0100, 8'h04}));
    push(2, 1'b1, 32'h0000_BEEF);
    tick();

    // Pointer wrap 3 -> 0, then 1
    set_port(0, 1'b1, 32'h10, 32'h0, 4'hF);
    set_port(1, 1'b1, 32'h10, 32'h0, 4'hF);
    req = 4'b0011;
    @(negedge clk);
    check("wrap_gnt0", 64'(gnt), 64'(4'b0001));
    push(0, 1'b1, 32'h0000_BEEF);
    tick();
    @(negedge clk);
    check("wrap_gnt1", 64'(gnt), 64'(4'b0010));
    push(1, 1'b1, 32'h0000_BEEF);
    tick();
    req = '0;
    @(negedge clk);
    check("no_req", 64'({mem_req, gnt}), 64'(0));
    tick();
    set_port(3, 1'b1, 32'h10, 32'h0, 4'hF);
    req = 4'b1101;
    @(negedge clk);
    check("rr_hold", 64'(gnt), 64'(4'b0100));
    push(2, 1'b1, 32'h0000_BEEF);
    tick();

    // init_i together with a granted read; response lands in first INIT cycle
    req = 4'b1000; init = 1'b1;
    @(negedge clk);
    check("init_gnt", 64'({gnt, init_done}), 64'({4'b1000, 1'b1}));
    push(3, 1'b1, 32'h0000_BEEF);
    tick();
    req = 4'hF;
    fill_check(256, 50);
    req = '0;
    @(negedge clk);
    check("reinit_done", 64'(init_done), 64'(1));
    tick();

    // Reset aborts an in-flight response
    set_port(0, 1'b1, 32'h10, 32'h0, 4'hF);
    req = 4'b0001;
    @(negedge clk);
    check("abort_gnt", 64'(gnt), 64'(4'b0001));
    tick();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("abort", 64'({r_valid, gnt, mem_req, init_done}), 64'(0));
    tick();
    rst = 1'b0;

    // Reset at fill count 100 restarts from word 0
    fill_check(100, 999);
    @(negedge clk);
    check("fill_100", 64'({mem_req, mem_addr}), 64'({1'b1, 8'd100}));
    #1 rst = 1'b1;
    #1 check("rst_mem_req", 64'(mem_req), 64'(0));
    tick();
    rst = 1'b0;
    fill_check(256, 999);
    @(negedge clk);
    check("rst_done", 64'(init_done), 64'(1));
    tick();

    // Pointer back to 0 after reset
    for (int i = 0; i < NR; i++) set_port(i, 1'b1, 32'(i * 4), 32'h0, 4'hF);
    req = 4'hF;
    @(negedge clk);
    check("ptr_reset", 64'(gnt), 64'(4'b0001));
    push(0, 1'b1, 32'h0);
    tick();
    req = '0;
    @(negedge clk);
    check("idle2", 64'({mem_req, gnt}), 64'(0));
    tick();
    req = 4'b1001;
    @(negedge clk);
    check("scan_from1", 64'(gnt), 64'(4'b1000));
    push(3, 1'b1, 32'h0);
    tick();
    req = '0;

`ifdef TCDM_ARB_PERF_EN
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    @(negedge clk);
    check("stall_clr0", 64'(stall_cnt), 64'(0));
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    req = 4'b0010;
    repeat (5) tick();
    req = '0;
    @(negedge clk);
    check("stall_5", 64'(stall_cnt), 64'({16'd0, 16'd0, 16'd5, 16'd0}));
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    @(negedge clk);
    check("stall_clr", 64'(stall_cnt), 64'(0));
    tick();
    for (int i = 0; i < 300 && !init_done; i++) tick();
    check("perf_done", 64'(init_done), 64'(1));
`endif

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
